sid_post_filter: RTL and testbench
==================================

Name: sid_post_filter

Overview:
- Analog back end of the SID audio path, from the voice mixers to the audio output.
- Input: a pre-filter voice sum and a filter-bypass voice sum. Output: one signed 16-bit sample.
- Contents: register-programmed state-variable filter (LP/BP/HP), post-filter mixer with DC offset, 17-to-16-bit clipper, 4-bit master volume, fixed ~15 kHz one-pole output lowpass.
- Register writes share the SID bus with the voice and envelope blocks.

Parameters:
- MIXER_WIDTH, 17, width of the post-filter mixer accumulator.
- MIXER_DC, -7489, signed DC offset added in the mixer.

Ports:
- clk  in  1  master clock
- iRstN  in  1  synchronous active-low reset
- clkEn  in  1  1 MHz sample enable, one clk wide
- iWE  in  1  register write strobe
- iAddr  in  5  SID register address
- iDataW  in  8  write data
- iIn  in  16 signed  pre-filter voice sum
- iBypass  in  16 signed  unfiltered voice sum
- oOut  out  16 signed  audio output

Behaviour:
- Reset (iRstN=0 at a clk edge), values on the next edge:
  - cutoff=0, res=0, mode=0, volume=0xF
  - lp, bp, hp, mixer, volume stage and oOut all 0
- Reset overrides everything in the same cycle.
- Writes (iWE=1), taking effect next clk independent of clkEn:
  - 0x15: cutoff[2:0] <= D[2:0]
  - 0x16: cutoff[10:3] <= D
  - 0x17: res <= D[7:4]
  - 0x18: mode <= D[6:4] (bit0 LP, bit1 BP, bit2 HP); volume <= D[3:0]
  - Other addresses are ignored.
- Coefficients (combinational from registers):
  - f = 12 + 2*cutoff + (cutoff>>1), 16-bit unsigned, Q0.16.
  - q = 5792 - 256*res, unsigned, Q.12 (1.414 down to 0.477).
- SVF update, only on clkEn; 16-bit signed states; all products widened to 32 bits; >>> is arithmetic (floor):
  - hp_n = sat16(iIn - lp - ((q*bp)>>>12))
  - bp_n = sat16(bp + ((f*hp_n)>>>16))
  - lp_n = sat16(lp + ((f*bp_n)>>>16))
  - All three registers load together.
  - sat16 clamps to [-32768, 32767].
- Mixer (every clk), result in a 17-bit signed register:
  - mix = iBypass + (mode[0]?lp:0) + (mode[1]?bp:0) + (mode[2]?hp:0) + MIXER_DC
- Clipper (combinational): mix > 32767 gives 32767; mix < -32768 gives -32768; otherwise passes through.
- Volume (every clk): vol_out = (clip*volume)>>>4, 20-bit signed product. volume=15 gives 15/16 gain; volume=0 gives 0.
- Output lowpass (only on clkEn): oOut <= oOut + (((vol_out - oOut)*3)>>>5). Difference uses 18 bits; alpha = 3/32, about 15.7 kHz at 1 MHz.
- Latency:
  - iBypass change to vol_out: 2 clk.
  - vol_out to oOut: first clkEn after that.
- oOut is registered and changes only on clkEn or reset.

Decomposition:
- Package sid_post_pkg holds:
  - register addresses 0x15–0x18
  - F_BASE=12, Q_BASE=5792, Q_STEP=256
  - MIXER_DC=-7489
  - output-LP coefficient 3 and shift 5
  - the sat16 function
- One sub-module, sid_svf: registers, coefficient mapping and state-variable update; outputs lp/bp/hp.
- Mixer, clipper, volume and output LP stay in the top.

Test Plan:
- Reset, then iIn=0, iBypass=0, no writes → oOut converges monotonically to exactly -7021 (clip -7489, *15>>>4).
- Write 0x18=0x0F, iBypass=16000 → vol_out=7979 two clk later; oOut converges to 7979. Write 0x18=0x00 → oOut decays to 0.
- iBypass=-32768, mode 0, volume 15 → mix=-40257, clipped to -32768, vol_out=-30720.
- Write 0x15=0x07, 0x16=0xFF, 0x17=0x00, 0x18=0x1F; step iIn 0→8000, iBypass=0 → lp settles to 8000; oOut settles to 479.
- Same cutoff, 0x18=0x4F (HP), iIn step 0→8000 → hp jumps near 8000 on first clkEn and then decays to 0; oOut returns to -7021.
- Mid-operation reset with lp≠0 → lp, bp, hp, oOut=0 and volume=15 the next clk; a write coincident with reset is discarded.

Source files
------------

// File: rtl/sid_post_pkg.sv
// Shared constants, register map and saturation helper for the SID analog back end.
package sid_post_pkg;

  typedef enum logic [4:0] {
    REG_FC_LO    = 5'h15,
    REG_FC_HI    = 5'h16,
    REG_RES      = 5'h17,
    REG_MODE_VOL = 5'h18
  } sid_reg_e;

  localparam int unsigned F_BASE    = 12;
  localparam int unsigned Q_BASE    = 5792;
  localparam int unsigned Q_STEP    = 256;
  localparam int          MIXER_DC  = -7489;
  localparam int          OLP_COEF  = 3;
  localparam int          OLP_SHIFT = 5;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    logic signed [15:0] r;
    if (x > 32'sd32767)       r = 16'sh7FFF;
    else if (x < -32'sd32768) r = 16'sh8000;
    else                      r = x[15:0];
    return r;
  endfunction

endpackage

// File: rtl/sid_svf.sv
// Filter control registers, cutoff/resonance coefficient mapping and the
// state-variable filter update (LP/BP/HP).
module sid_svf
  import sid_post_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clk_en_i,
  input  logic               we_i,
  input  logic [4:0]         addr_i,
  input  logic [7:0]         data_i,
  input  logic signed [15:0] in_i,
  output logic signed [15:0] lp_o,
  output logic signed [15:0] bp_o,
  output logic signed [15:0] hp_o,
  output logic [2:0]         mode_o,
  output logic [3:0]         volume_o
);

  logic [10:0]        cutoff_q, cutoff_d;
  logic [3:0]         res_q, res_d;
  logic [2:0]         mode_q, mode_d;
  logic [3:0]         volume_q, volume_d;
  logic [15:0]        f_coef, q_coef;
  logic signed [31:0] q_bp, f_hp, f_bp;
  logic signed [15:0] lp_q, lp_d, bp_q, bp_d, hp_q, hp_d;

  always_comb begin
    cutoff_d = cutoff_q;
    res_d    = res_q;
    mode_d   = mode_q;
    volume_d = volume_q;
    if (we_i) begin
      case (addr_i)
        REG_FC_LO:    cutoff_d[2:0]  = data_i[2:0];
        REG_FC_HI:    cutoff_d[10:3] = data_i;
        REG_RES:      res_d          = data_i[7:4];
        REG_MODE_VOL: begin
          mode_d   = data_i[6:4];
          volume_d = data_i[3:0];
        end
        default: ;
      endcase
    end
  end

  // f ~= 2.5*cutoff + base (Q0.16); q falls linearly with resonance (Q.12)
  assign f_coef = 16'(F_BASE) + {4'b0, cutoff_q, 1'b0} + {6'b0, cutoff_q[10:1]};
  assign q_coef = 16'(Q_BASE) - 16'(Q_STEP * res_q);

  always_comb begin
    q_bp = $signed({16'b0, q_coef}) * 32'(bp_q);
    hp_d = sat16(32'(in_i) - 32'(lp_q) - (q_bp >>> 12));
    f_hp = $signed({16'b0, f_coef}) * 32'(hp_d);
    bp_d = sat16(32'(bp_q) + (f_hp >>> 16));
    f_bp = $signed({16'b0, f_coef}) * 32'(bp_d);
    lp_d = sat16(32'(lp_q) + (f_bp >>> 16));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cutoff_q <= '0;
      res_q    <= '0;
      mode_q   <= '0;
      volume_q <= '1;
      lp_q     <= '0;
      bp_q     <= '0;
      hp_q     <= '0;
    end else begin
      cutoff_q <= cutoff_d;
      res_q    <= res_d;
      mode_q   <= mode_d;
      volume_q <= volume_d;
      if (clk_en_i) begin
        lp_q <= lp_d;
        bp_q <= bp_d;
        hp_q <= hp_d;
      end
    end
  end

  assign lp_o     = lp_q;
  assign bp_o     = bp_q;
  assign hp_o     = hp_q;
  assign mode_o   = mode_q;
  assign volume_o = volume_q;

endmodule

// File: rtl/sid_post_filter.sv
// SID analog back end: state-variable filter, post-filter mixer with DC offset,
// 17-to-16-bit clipper, master volume and fixed one-pole output lowpass.
module sid_post_filter #(
  parameter int MIXER_WIDTH = 17,
  parameter int MIXER_DC    = sid_post_pkg::MIXER_DC
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iWE,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iDataW,
  input  logic signed [15:0] iIn,
  input  logic signed [15:0] iBypass,
  output logic signed [15:0] oOut
);
  import sid_post_pkg::*;

  logic signed [15:0]            lp, bp, hp;
  logic [2:0]                    mode;
  logic [3:0]                    volume;
  logic signed [31:0]            mix_sum;
  logic signed [MIXER_WIDTH-1:0] mix_q, mix_d;
  logic signed [15:0]            clip;
  logic signed [19:0]            vol_prod;
  logic signed [15:0]            vol_q, vol_d;
  logic signed [17:0]            olp_diff;
  logic signed [19:0]            olp_step;
  logic signed [15:0]            out_q, out_d;

  sid_svf u_svf (
    .clk_i    (clk),
    .rst_ni   (iRstN),
    .clk_en_i (clkEn),
    .we_i     (iWE),
    .addr_i   (iAddr),
    .data_i   (iDataW),
    .in_i     (iIn),
    .lp_o     (lp),
    .bp_o     (bp),
    .hp_o     (hp),
    .mode_o   (mode),
    .volume_o (volume)
  );

  always_comb begin
    mix_sum = 32'(iBypass) + 32'(MIXER_DC);
    if (mode[0]) mix_sum = mix_sum + 32'(lp);
    if (mode[1]) mix_sum = mix_sum + 32'(bp);
    if (mode[2]) mix_sum = mix_sum + 32'(hp);
    mix_d = MIXER_WIDTH'(mix_sum);
  end

  always_comb begin
    if (32'(mix_q) > 32'sd32767)       clip = 16'sh7FFF;
    else if (32'(mix_q) < -32'sd32768) clip = 16'sh8000;
    else                               clip = mix_q[15:0];
  end

  assign vol_prod = 20'(clip) * $signed({16'b0, volume});
  assign vol_d    = 16'(vol_prod >>> 4);

  // alpha = 3/32 one-pole lowpass; floor shift keeps it bit-exact with the reference
  assign olp_diff = 18'(vol_q) - 18'(out_q);
  assign olp_step = (20'(olp_diff) * 20'(OLP_COEF)) >>> OLP_SHIFT;
  assign out_d    = out_q + 16'(olp_step);

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      mix_q <= '0;
      vol_q <= '0;
      out_q <= '0;
    end else begin
      mix_q <= mix_d;
      vol_q <= vol_d;
      if (clkEn) out_q <= out_d;
    end
  end

  assign oOut = out_q;

endmodule

// File: tb/tb_sid_post_filter.sv
// Scoreboard bench for sid_post_filter: stimulus pushes expected oOut per sample,
// a monitor pops and compares on every clkEn or reset edge.
module tb_sid_post_filter;

  logic               clk = 1'b0;
  logic               iRstN, clkEn, iWE;
  logic [4:0]         iAddr;
  logic [7:0]         iDataW;
  logic signed [15:0] iIn, iBypass, oOut;

  always #5 clk = ~clk;

  sid_post_filter #(.MIXER_WIDTH(17), .MIXER_DC(-7489)) dut (
    .clk     (clk),
    .iRstN   (iRstN),
    .clkEn   (clkEn),
    .iWE     (iWE),
    .iAddr   (iAddr),
    .iDataW  (iDataW),
    .iIn     (iIn),
    .iBypass (iBypass),
    .oOut    (oOut)
  );

  typedef struct packed {
    int   exp;
    logic hand;
    int   lo;
    int   hi;
    int   tag;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  int m_cut, m_res, m_mode, m_vol, m_lp, m_bp, m_hp, m_out;

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "dc_settle";
      2: return "bypass_pos";
      3: return "vol_zero";
      4: return "bypass_clip";
      5: return "lp_step";
      6: return "mid_reset";
      7: return "post_reset";
      8: return "hp_first";
      9: return "hp_second";
      10: return "hp_decay";
      default: return "unknown";
    endcase
  endfunction

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset();
    m_cut = 0; m_res = 0; m_mode = 0; m_vol = 15;
    m_lp = 0; m_bp = 0; m_hp = 0; m_out = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    case (a)
      'h15: m_cut = (m_cut & 'h7F8) | (d & 7);
      'h16: m_cut = (m_cut & 7) | (d << 3);
      'h17: m_res = d >> 4;
      'h18: begin m_mode = (d >> 4) & 7; m_vol = d & 15; end
      default: ;
    endcase
  endfunction

  // Output stage sees the filter state from before this sample's update.
  function automatic void model_sample();
    int f, q, mix, clp, vo, hpn, bpn, lpn;
    f   = 12 + 2 * m_cut + (m_cut >> 1);
    q   = 5792 - 256 * m_res;
    mix = int'(iBypass) - 7489;
    if ((m_mode & 1) != 0) mix += m_lp;
    if ((m_mode & 2) != 0) mix += m_bp;
    if ((m_mode & 4) != 0) mix += m_hp;
    clp   = (mix > 32767) ? 32767 : ((mix < -32768) ? -32768 : mix);
    vo    = (clp * m_vol) >>> 4;
    m_out = m_out + (((vo - m_out) * 3) >>> 5);
    hpn = sat(int'(iIn) - m_lp - ((q * m_bp) >>> 12));
    bpn = sat(m_bp + ((f * hpn) >>> 16));
    lpn = sat(m_lp + ((f * bpn) >>> 16));
    m_hp = hpn; m_bp = bpn; m_lp = lpn;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    iWE = 1'b1; iAddr = a; iDataW = d;
    @(negedge clk);
    iWE = 1'b0;
    model_write(int'(a), int'(d));
  endtask

  // n samples, clkEn every 4th clk; optional hand range on the last one
  task automatic step(input int n, input int tag, input logic hand_last,
                      input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      model_sample();
      sb_q.push_back('{exp: m_out, hand: (hand_last && (i == n - 1)), lo: lo, hi: hi, tag: tag});
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
    end
  endtask

  // Reset edge, optionally with a coincident write (vol=0) and clkEn that must be ignored
  task automatic do_reset(input int tag, input logic with_junk);
    @(negedge clk);
    iRstN = 1'b0;
    if (with_junk) begin
      iWE = 1'b1; iAddr = 5'h18; iDataW = 8'h00; clkEn = 1'b1;
    end
    model_reset();
    sb_q.push_back('{exp: 0, hand: 1'b1, lo: 0, hi: 0, tag: tag});
    @(negedge clk);
    iRstN = 1'b1; iWE = 1'b0; clkEn = 1'b0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    if (!iRstN || clkEn) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: oOut=%0d but no expected value queued", oOut);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (int'(oOut) != e.exp) begin
          errors++;
          $display("FAIL %s: oOut=%0d required %0d", tag_name(e.tag), oOut, e.exp);
        end
        if (e.hand) begin
          checks++;
          if (int'(oOut) < e.lo || int'(oOut) > e.hi) begin
            errors++;
            $display("FAIL %s_final: oOut=%0d required in [%0d,%0d]",
                     tag_name(e.tag), oOut, e.lo, e.hi);
          end
        end
      end
    end
  end

  initial begin
    iRstN = 1'b1; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iDataW = '0;
    iIn = '0; iBypass = '0;
    model_reset();

    do_reset(0, 1'b0);
    // silence: clip(-7489)*15>>>4 = -7021, approached from above so exact
    step(120, 1, 1'b1, -7021, -7021);

    // 16000-7489=8511, *15>>>4 = 7979; rising approach stalls up to 10 below
    wr(5'h18, 8'h0F);
    iBypass = 16'sd16000;
    step(120, 2, 1'b1, 7969, 7979);

    wr(5'h18, 8'h00);
    step(150, 3, 1'b1, 0, 0);

    // -32768-7489 = -40257 clips to -32768, *15>>>4 = -30720
    wr(5'h18, 8'h0F);
    iBypass = 16'sh8000;
    step(130, 4, 1'b1, -30720, -30720);

    iBypass = '0;
    wr(5'h15, 8'h07);
    wr(5'h16, 8'hFF);
    wr(5'h17, 8'h00);
    wr(5'h18, 8'h1F);
    iIn = 16'sd8000;
    // lp=8000 gives 479; floor deadband can leave lp up to ~28 short (>= 442)
    step(250, 5, 1'b1, 440, 479);

    iIn = '0;
    do_reset(6, 1'b1);
    step(120, 7, 1'b1, -7021, -7021);

    wr(5'h15, 8'h07);
    wr(5'h16, 8'hFF);
    wr(5'h17, 8'h00);
    wr(5'h18, 8'h4F);
    iIn = 16'sd8000;
    // first sample: output still sees hp=0; second: hp=8000 -> vol 479, -7021+703
    step(1, 8, 1'b1, -7021, -7021);
    step(1, 9, 1'b1, -6318, -6318);
    // hp rests in [0,12] -> vol in [-7021,-7010]
    step(250, 10, 1'b1, -7031, -7010);

    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d samples never presented, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
